// File: rtl/sum_arbiter.sv
// sum_arbiter: round-robin owner arbitration for one shared combinational adder.
// A requester keeps the adder for as long as it holds req. Its operands are
// steered onto the adder, the result is broadcast to everyone, and long holds
// are tracked by a saturating counter with a sticky overrun flag.
module sum_arbiter #(
    parameter int N_REQ    = 2,
    parameter int WIDTH    = 16,
    parameter int MAX_HOLD = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] op_a,
    input  logic [N_REQ*WIDTH-1:0] op_b,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       sum_in_a,
    output logic [WIDTH-1:0]       sum_in_b,
    input  logic [WIDTH-1:0]       sum_out,
    output logic [WIDTH-1:0]       res,
    output logic                   busy,
    output logic [7:0]             hold_cnt,
    output logic                   hold_err
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic               hold_err_q, hold_err_d;

    logic [IDX_W-1:0]   owner_next;
    logic [IDX_W-1:0]   search_start;
    logic [IDX_W-1:0]   win_idx;
    logic               win_found;
    logic [WIDTH-1:0]   mux_a, mux_b;

    // Successor of the current owner (wraps) and where the round-robin search begins.
    always_comb begin
        owner_next   = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
        search_start = (state_q == OWN) ? owner_next : rr_q;
    end

    // Find the first requester at or after search_start, wrapping modulo N_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int off = 0; off < N_REQ; off++) begin
            if (!win_found && req[(int'(search_start) + off) % N_REQ]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'((int'(search_start) + off) % N_REQ);
            end
        end
    end

    // Next-state logic: grant from idle, hold while req stays up, hand over on release.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        hold_cnt_d = hold_cnt_q;
        hold_err_d = hold_err_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d    = OWN;
                    owner_d    = win_idx;
                    gnt_d      = N_REQ'(1) << win_idx;
                    hold_cnt_d = 8'd0;
                end
            end
            OWN: begin
                if (req[owner_q]) begin
                    // Owner keeps the adder; the watchdog only reports, never preempts.
                    if (hold_cnt_q != 8'hFF) begin
                        hold_cnt_d = hold_cnt_q + 8'd1;
                    end
                    if (int'(hold_cnt_d) == MAX_HOLD + 1) begin
                        hold_err_d = 1'b1;
                    end
                end else begin
                    // Release: advance the pointer past the owner and hand over in the same edge.
                    rr_d       = owner_next;
                    hold_cnt_d = 8'd0;
                    if (win_found) begin
                        owner_d = win_idx;
                        gnt_d   = N_REQ'(1) << win_idx;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d    = IDLE;
                gnt_d      = '0;
                hold_cnt_d = 8'd0;
            end
        endcase
    end

    // Arbiter state registers; reset drops any grant immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            rr_q       <= '0;
            hold_cnt_q <= 8'd0;
            hold_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            hold_cnt_q <= hold_cnt_d;
            hold_err_q <= hold_err_d;
        end
    end

    // Operand mux driven from the registered one-hot grant; zero when nobody owns the adder.
    always_comb begin
        mux_a = '0;
        mux_b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt_q[i]) begin
                mux_a = mux_a | op_a[i*WIDTH +: WIDTH];
                mux_b = mux_b | op_b[i*WIDTH +: WIDTH];
            end
        end
    end

    assign gnt      = gnt_q;
    assign sum_in_a = mux_a;
    assign sum_in_b = mux_b;
    assign res      = sum_out;
    assign busy     = |gnt_q;
    assign hold_cnt = hold_cnt_q;
    assign hold_err = hold_err_q;

endmodule

// File: tb/tb_sum_arbiter.sv
// tb_sum_arbiter: randomized and directed stimulus for sum_arbiter, checked
// through a scoreboard fed by a behavioural arbitration model.
module tb_sum_arbiter;

    localparam int N    = 2;
    localparam int W    = 16;
    localparam int MAXH = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] op_a, op_b;
    logic [N-1:0]   gnt;
    logic [W-1:0]   sum_in_a, sum_in_b, sum_out, res;
    logic           busy;
    logic [7:0]     hold_cnt;
    logic           hold_err;

    sum_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
        .gnt(gnt), .sum_in_a(sum_in_a), .sum_in_b(sum_in_b),
        .sum_out(sum_out), .res(res), .busy(busy),
        .hold_cnt(hold_cnt), .hold_err(hold_err)
    );

    // The shared adder: plain W-bit add, carry discarded.
    assign sum_out = sum_in_a + sum_in_b;

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: owner index (-1 = none), round-robin start, hold time, sticky error.
    int           m_owner = -1;
    int           m_rr    = 0;
    int           m_hold  = 0;
    bit           m_err   = 1'b0;
    logic [N-1:0] prev_req = '0;

    typedef struct {
        logic [N-1:0] gnt;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic         busy;
        logic [7:0]   hold;
        logic         err;
    } exp_t;

    exp_t sb[$];

    function automatic int pick(input int start, input logic [N-1:0] r);
        for (int o = 0; o < N; o++) begin
            if (r[(start + o) % N]) return (start + o) % N;
        end
        return -1;
    endfunction

    // Apply one rising edge to the model using the requests that were present at it.
    task automatic model_edge();
        if (m_owner < 0) begin
            m_owner = pick(m_rr, prev_req);
            m_hold  = 0;
        end else if (prev_req[m_owner]) begin
            if (m_hold < 255) m_hold++;
            if (m_hold == MAXH + 1) m_err = 1'b1;
        end else begin
            m_rr    = (m_owner + 1) % N;
            m_owner = pick(m_rr, prev_req);
            m_hold  = 0;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.gnt = '0;
        e.a   = '0;
        e.b   = '0;
        if (m_owner >= 0) begin
            e.gnt[m_owner] = 1'b1;
            e.a = op_a[m_owner*W +: W];
            e.b = op_b[m_owner*W +: W];
        end
        e.res  = e.a + e.b;
        e.busy = (m_owner >= 0);
        e.hold = 8'(m_hold);
        e.err  = m_err;
        sb.push_back(e);
    endtask

    task automatic step_edge();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic step_drive(input logic [N-1:0] r, input logic [W-1:0] a0, input logic [W-1:0] b0,
                              input logic [W-1:0] a1, input logic [W-1:0] b1);
        req      = r;
        op_a     = {a1, a0};
        op_b     = {b1, b0};
        prev_req = r;
        push_exp();
    endtask

    task automatic step(input logic [N-1:0] r);
        step_edge();
        step_drive(r, W'($urandom), W'($urandom), W'($urandom), W'($urandom));
    endtask

    // Assert reset between edges and confirm the outputs collapse without a clock edge.
    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_gnt",  32'(gnt), 32'(0));
        check("rst_a",    32'(sum_in_a), 32'(0));
        check("rst_b",    32'(sum_in_b), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_hold", 32'(hold_cnt), 32'(0));
        check("rst_err",  32'(hold_err), 32'(0));
        sb.delete();
        m_owner = -1;
        m_rr    = 0;
        m_hold  = 0;
        m_err   = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Monitor: pop one expectation per sampled cycle and compare every output.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("gnt",      32'(gnt),      32'(e.gnt));
            check("sum_in_a", 32'(sum_in_a), 32'(e.a));
            check("sum_in_b", 32'(sum_in_b), 32'(e.b));
            check("res",      32'(res),      32'(e.res));
            check("busy",     32'(busy),     32'(e.busy));
            check("hold_cnt", 32'(hold_cnt), 32'(e.hold));
            check("hold_err", 32'(hold_err), 32'(e.err));
            check("onehot",   32'($countones(gnt) <= 1), 32'(1));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [W-1:0] mul_acc;
        int           mul_cnt;
        logic [W-1:0] stub_res;
        bit           stub_done;
        logic [N-1:0] r;

        rst  = 1'b1;
        req  = '0;
        op_a = '0;
        op_b = '0;

        // Single requester: 3 + 2 through the shared adder, then release.
        do_reset();
        step_edge(); step_drive(2'b01, 16'd3, 16'd2, 16'd0, 16'd0);
        repeat (3) begin step_edge(); step_drive(2'b01, 16'd3, 16'd2, 16'd0, 16'd0); end
        repeat (3) step(2'b00);

        // Tie after reset goes to requester 0, then hands over without a gap.
        do_reset();
        repeat (3) step(2'b11);
        repeat (3) step(2'b10);
        repeat (2) step(2'b00);

        // Fairness: requester 0 drops for one cycle while 1 is pending.
        step(2'b01);
        repeat (5) step(2'b11);
        step(2'b10);
        repeat (3) step(2'b11);
        repeat (3) step(2'b01);
        repeat (2) step(2'b00);

        // Hold watchdog: sticky error without preemption, cleared by reset.
        do_reset();
        repeat (11) step(2'b01);
        repeat (3) step(2'b00);

        // Asynchronous reset while requester 1 owns the adder.
        do_reset();
        repeat (3) step(2'b10);
        step(2'b11);
        do_reset();
        repeat (3) step(2'b11);
        repeat (2) step(2'b00);

        // Hold counter saturation.
        do_reset();
        repeat (262) step(2'b01);
        repeat (2) step(2'b00);

        // Iterative multiply 255*255 on slot 0 alongside a single 100+200 on slot 1.
        do_reset();
        mul_acc   = '0;
        mul_cnt   = 0;
        stub_res  = '0;
        stub_done = 1'b0;
        for (int cyc = 0; cyc < 700 && !(mul_cnt == 255 && stub_done); cyc++) begin
            step_edge();
            r[0] = (mul_cnt < 255);
            r[1] = !stub_done;
            step_drive(r, mul_acc, 16'd255, 16'd100, 16'd200);
            @(negedge clk);
            #1;
            if (m_owner == 0 && r[0]) begin
                mul_acc = res;
                mul_cnt++;
            end
            if (m_owner == 1 && r[1]) begin
                stub_res  = res;
                stub_done = 1'b1;
            end
        end
        check("mul_done",   32'(mul_cnt), 32'(255));
        check("stub_done",  32'(stub_done), 32'(1));
        check("mul_result", 32'(mul_acc), 32'(65025));
        check("stub_res",   32'(stub_res), 32'(300));
        repeat (2) step(2'b00);

        // Random request patterns and operands.
        do_reset();
        repeat (400) step(N'($urandom));
        repeat (2) step(2'b00);

        @(posedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_arbiter.md
Name: sum_arbiter

Overview:
Round-robin arbiter that shares the single combinational `sum` adder between N requesters, e.g. `mul` and a second iterative unit.
A requester holds `req` high for its whole operation and owns the adder until it drops `req`.
The block muxes the owner's operands onto the adder inputs and broadcasts the adder result to all requesters.
It also tracks grant hold time and flags overlong holds.

Parameters:
N_REQ, 2, number of requesters (2..8)
WIDTH, 16, adder operand/result width in bits
MAX_HOLD, 64, hold-cycle limit; exceeding it sets hold_err

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req  input  N_REQ  per-requester request; bit i held high while requester i needs the adder
op_a  input  N_REQ*WIDTH  flattened operand A; slice i = op_a[i*WIDTH +: WIDTH]
op_b  input  N_REQ*WIDTH  flattened operand B, same packing
gnt  output  N_REQ  one-hot grant, registered
sum_in_a  output  WIDTH  to sum.a
sum_in_b  output  WIDTH  to sum.b
sum_out  input  WIDTH  from sum.result
res  output  WIDTH  adder result broadcast to all requesters
busy  output  1  1 while any grant is active
hold_cnt  output  8  cycles the current owner has held the grant, saturating at 255
hold_err  output  1  sticky; set when hold_cnt exceeds MAX_HOLD

Behaviour:
- Reset (async, immediate):
  - gnt=0, busy=0, hold_cnt=0, hold_err=0.
  - Round-robin pointer rr=0.
  - sum_in_a=sum_in_b=0, since they follow gnt.
- Reset mid-operation drops the grant at once. The requester must restart.
- FSM states:
  - IDLE (gnt=0).
  - OWN (exactly one gnt bit set).
- IDLE:
  - If req != 0, at the next rising edge grant the first requester with req=1, searching i = rr, rr+1, ..., wrapping mod N_REQ. Go to OWN.
  - Grant latency is one cycle from req rising to gnt rising.
- OWN, owner k:
  - While req[k]=1, gnt[k] stays set. No preemption, even on hold_err.
  - If req[k]=0 at a rising edge:
    - rr <= (k+1) mod N_REQ.
    - In the same edge, grant the next pending requester, searching from k+1 with wrap. No idle gap cycle.
    - If none is pending, go to IDLE.
  - A requester that drops and reasserts req in consecutive cycles does not win if another requester is pending (fairness).
- Simultaneous requests: the winner is the lowest index at or after rr, with wrap-around. After reset, requester 0 wins a tie.
- Operand mux (combinational from registered gnt):
  - sum_in_a/sum_in_b = slice k of op_a/op_b when gnt[k]=1.
  - Otherwise both are 0.
- res = sum_out combinationally, valid for the owner in any cycle it holds gnt. Width rules follow `sum` (WIDTH-bit, carry discarded).
- busy = |gnt.
- hold_cnt:
  - Cleared to 0 on every grant change (new owner or to IDLE).
  - Increments by 1 per cycle while the same owner holds; saturates at 255.
- hold_err: set at the edge where hold_cnt becomes MAX_HOLD+1. Cleared only by rst.
- req bits for indices with no pending work must be 0. X on req is a verification error.

Test Plan:
1. Single requester: N_REQ=2, req=01, op_a slice0=3, op_b slice0=2.
   -> gnt=01 one cycle after req.
   -> sum_in_a=3, sum_in_b=2, res=5.
   -> Drop req -> gnt=00 and busy=0 next edge.
2. Tie after reset: req=11 in the same cycle.
   -> gnt=01 first.
   -> Requester 0 drops req -> gnt=10 on the same edge, no idle cycle, and hold_cnt restarts at 0.
3. Fairness: requester 0 holds 5 cycles, drops for 1 cycle and reasserts, while requester 1 is pending.
   -> gnt goes to 10.
   -> After requester 1 drops, gnt returns to 01.
4. Integrated with mul: mul on slot 0 computing 255*255, a stub adding 100+200 on slot 1, both requesting.
   -> mul result=65025 and stub res=300.
   -> No cycle with two gnt bits set.
5. Hold watchdog: MAX_HOLD=4, hold req=01 for 10 cycles.
   -> hold_err rises when hold_cnt=5 and stays 1 after req drops.
   -> The grant is never revoked.
   -> rst clears hold_err.
6. Async reset mid-grant: assert rst between clock edges while gnt=10.
   -> gnt=00 and sum_in_a=0 immediately, without waiting for an edge.
   -> After release with req=11, gnt=01 (rr back to 0).
